// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with parity/framing/overrun pulses and a valid/ready byte output
module uart_rx_core #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [31:0]          delitel,
    input  logic [2:0]           parity_bit_mode,
    input  logic                 stop_bit_num,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 err_rx,
    output logic                 err_stop,
    output logic                 err_rx_dropped
);
    localparam int BW = $clog2(DATA_BITS + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE} state_t;
    state_t               state;
    logic [SYNC_STAGES-1:0] sync;
    logic                 rxs;
    logic [31:0]          cnt, div, lim;
    logic [2:0]           pmode;
    logic                 two_stop, par_err, tick, par_exp, has_par, done, ferr;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    assign rxs     = sync[SYNC_STAGES-1];
    // START waits half a bit to land mid-bit; every later sample is a full bit apart
    assign lim     = (state == START) ? (div >> 1) - 32'd1 : div - 32'd1;
    assign tick    = cnt == lim;
    assign has_par = (pmode != 3'd0) && (pmode <= 3'd4);
    assign par_exp = (pmode == 3'd1) ? ^shreg : (pmode == 3'd2) ? ~^shreg : (pmode == 3'd3);
    assign done    = tick && rxs && ((state == STOP1 && !two_stop) || state == STOP2);
    assign ferr    = tick && !rxs && (state == STOP1 || state == STOP2);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync <= '1;
        else
            sync <= {sync[SYNC_STAGES-2:0], rx};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            div            <= 32'd2;
            pmode          <= '0;
            two_stop       <= 1'b0;
            par_err        <= 1'b0;
            shreg          <= '0;
            bit_cnt        <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            err_rx         <= 1'b0;
            err_stop       <= 1'b0;
            err_rx_dropped <= 1'b0;
        end else begin
            err_rx         <= 1'b0;
            err_rx_dropped <= 1'b0;
            err_stop       <= ferr;
            cnt            <= tick ? 32'd0 : cnt + 32'd1;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    err_rx_dropped <= 1'b1;
                end
                err_rx <= par_err;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state    <= START;
                        div      <= (delitel < 32'd2) ? 32'd2 : delitel;
                        pmode    <= parity_bit_mode;
                        two_stop <= stop_bit_num;
                        par_err  <= 1'b0;
                        bit_cnt  <= '0;
                    end
                end
                START: if (tick) state <= rxs ? IDLE : DATA;
                DATA: if (tick) begin
                    shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_BITS - 1))
                        state <= has_par ? PARITY : STOP1;
                end
                PARITY: if (tick) begin
                    par_err <= rxs != par_exp;
                    state   <= STOP1;
                end
                STOP1: if (tick) state <= !rxs ? WAIT_IDLE : two_stop ? STOP2 : IDLE;
                STOP2: if (tick) state <= rxs ? IDLE : WAIT_IDLE;
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frame vectors plus hand sequences for overrun, break, glitch, reset and config changes
module tb_uart_rx_core;
    localparam int SYNC = 2;
    logic        clk = 0, rst_n = 0, rx = 1, stop_bit_num = 0, rx_ready = 1;
    logic [31:0] delitel = 16;
    logic [2:0]  parity_bit_mode = 0;
    logic [7:0]  rx_data;
    logic        rx_valid, err_rx, err_stop, err_rx_dropped;
    int total = 0, bad = 0;
    int cyc = 0, stop_cyc = 0, valid_cyc = 0;
    int n_acc = 0, n_vcyc = 0, n_erx = 0, n_est = 0, n_drop = 0;
    logic [7:0] last_acc = 0;
    logic pv = 0;
    event last_stop_ev;

    uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .delitel(delitel),
        .parity_bit_mode(parity_bit_mode), .stop_bit_num(stop_bit_num),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err_rx(err_rx), .err_stop(err_stop), .err_rx_dropped(err_rx_dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_rx) n_erx++;
            if (err_stop) n_est++;
            if (err_rx_dropped) n_drop++;
            if (rx_valid) n_vcyc++;
            if (rx_valid && rx_ready) begin
                n_acc++;
                last_acc = rx_data;
            end
            if (rx_valid && !pv) valid_cyc = cyc;
            pv = rx_valid;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int dl, input bit par, input logic pb,
                              input bit two, input logic s1, input logic s2);
        drive(1'b0, dl);
        for (int i = 0; i < 8; i++) drive(d[i], dl);
        if (par) drive(pb, dl);
        if (two) begin
            drive(s1, dl);
            stop_cyc = cyc;
            -> last_stop_ev;
            drive(s2, dl);
        end else begin
            stop_cyc = cyc;
            -> last_stop_ev;
            drive(s1, dl);
        end
        drive(1'b1, 2 * dl + 8);
    endtask

    typedef struct {
        logic [7:0] d;
        int dl, pm;
        logic pb;
        bit two;
        logic s2;
        int acc, erx, est;
    } vec_t;
    vec_t v[12];

    int b_acc, b_vcyc, b_erx, b_est, b_drop, d, lat;

    task automatic snap();
        b_acc = n_acc; b_vcyc = n_vcyc; b_erx = n_erx; b_est = n_est; b_drop = n_drop;
    endtask

    initial begin
        v = '{
            '{8'hA5, 16, 0, 1'b0, 1'b0, 1'b1, 1, 0, 0},
            '{8'h3C, 16, 1, 1'b1, 1'b0, 1'b1, 1, 1, 0},
            '{8'h3C, 16, 1, 1'b0, 1'b0, 1'b1, 1, 0, 0},
            '{8'h3C, 16, 2, 1'b1, 1'b0, 1'b1, 1, 0, 0},
            '{8'h01, 16, 3, 1'b0, 1'b0, 1'b1, 1, 1, 0},
            '{8'h01, 16, 4, 1'b0, 1'b0, 1'b1, 1, 0, 0},
            '{8'h55, 10, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1},
            '{8'h12, 10, 0, 1'b0, 1'b1, 1'b1, 1, 0, 0},
            '{8'hC3,  3, 0, 1'b0, 1'b0, 1'b1, 1, 0, 0},
            '{8'h96,  0, 5, 1'b0, 1'b0, 1'b1, 1, 0, 0},
            '{8'h7E,  1, 2, 1'b0, 1'b0, 1'b1, 1, 1, 0},
            '{8'h81,  7, 1, 1'b0, 1'b1, 1'b1, 1, 0, 0}
        };
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rx_data, rx_valid, err_rx, err_stop, err_rx_dropped}, 0);
        rst_n = 1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            delitel = v[i].dl;
            parity_bit_mode = 3'(v[i].pm);
            stop_bit_num = v[i].two;
            d = (v[i].dl < 2) ? 2 : v[i].dl;
            snap();
            send_frame(v[i].d, d, v[i].pm >= 1 && v[i].pm <= 4, v[i].pb, v[i].two, 1'b1, v[i].s2);
            chk($sformatf("v%0d_acc", i), n_acc - b_acc, v[i].acc);
            chk($sformatf("v%0d_vcyc", i), n_vcyc - b_vcyc, v[i].acc);
            chk($sformatf("v%0d_err_rx", i), n_erx - b_erx, v[i].erx);
            chk($sformatf("v%0d_err_stop", i), n_est - b_est, v[i].est);
            chk($sformatf("v%0d_drop", i), n_drop - b_drop, 0);
            if (v[i].acc == 1) begin
                chk($sformatf("v%0d_data", i), last_acc, v[i].d);
                lat = valid_cyc - stop_cyc;
                chk($sformatf("v%0d_latency_ok(lat=%0d)", i, lat),
                    (lat >= d / 2 && lat <= d / 2 + 2 + SYNC), 1);
            end
        end

        // framing error followed by a held break, then recovery
        delitel = 10; parity_bit_mode = 0; stop_bit_num = 1;
        snap();
        drive(1'b0, 10);
        for (int i = 0; i < 8; i++) drive(i[0] ? 1'b0 : 1'b1, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b0, 40);
        drive(1'b1, 20);
        chk("break_err_stop", n_est - b_est, 1);
        chk("break_no_valid", n_vcyc - b_vcyc, 0);
        send_frame(8'h12, 10, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("break_next_acc", n_acc - b_acc, 1);
        chk("break_next_data", last_acc, 8'h12);

        // overrun, then ready arriving exactly on completion
        delitel = 16; stop_bit_num = 0; rx_ready = 0;
        snap();
        send_frame(8'h11, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_first_valid", rx_valid, 1);
        chk("ovr_first_data", rx_data, 8'h11);
        send_frame(8'h22, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_keep_data", rx_data, 8'h11);
        chk("ovr_drop", n_drop - b_drop, 1);
        chk("ovr_still_valid", rx_valid, 1);
        snap();
        fork
            send_frame(8'h33, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                @(last_stop_ev);
                repeat (8 + SYNC) @(negedge clk);
                rx_ready = 1;
            end
        join
        chk("coinc_data", rx_data, 8'h33);
        chk("coinc_no_drop", n_drop - b_drop, 0);
        chk("coinc_acc", n_acc - b_acc, 2);
        chk("coinc_last", last_acc, 8'h33);
        chk("coinc_valid_clear", rx_valid, 0);

        // short low glitch must be rejected as a false start
        snap();
        drive(1'b0, 4);
        drive(1'b1, 40);
        chk("glitch_quiet", {n_vcyc - b_vcyc, n_erx - b_erx, n_est - b_est, n_drop - b_drop}, 0);
        send_frame(8'h80, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("glitch_next_acc", n_acc - b_acc, 1);
        chk("glitch_next_data", last_acc, 8'h80);

        // configuration changes mid-frame apply only to the next frame
        snap();
        fork
            send_frame(8'h5A, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (50) @(negedge clk);
                delitel = 3; parity_bit_mode = 3; stop_bit_num = 1;
            end
        join
        chk("cfg_acc", n_acc - b_acc, 1);
        chk("cfg_data", last_acc, 8'h5A);
        chk("cfg_errs", {n_erx - b_erx, n_est - b_est}, 0);
        delitel = 16; parity_bit_mode = 0; stop_bit_num = 0;

        // reset mid-frame with a byte pending
        rx_ready = 0;
        send_frame(8'h77, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_pending", {rx_valid, rx_data}, {1'b1, 8'h77});
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(1'b1, 16);
        drive(1'b0, 8);
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {rx_data, rx_valid, err_rx, err_stop, err_rx_dropped}, 0);
        rx = 1;
        rst_n = 1;
        rx_ready = 1;
        repeat (20) @(negedge clk);
        snap();
        send_frame(8'hF0, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_next_acc", n_acc - b_acc, 1);
        chk("rst_next_data", last_acc, 8'hF0);
        chk("rst_next_errs", {n_erx - b_erx, n_est - b_est, n_drop - b_drop}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive engine sitting directly downstream of the APB UART register block. It consumes that block's delitel, parity_bit_mode and stop_bit_num configuration outputs. It deserialises the rx line into bytes, presented on a valid/ready interface. It returns single-cycle err_rx (parity), err_stop (framing) and err_rx_dropped (overrun) pulses to the register block's sticky status bits.

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first
SYNC_STAGES, 2, flops in rx input synchroniser (min 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
rx  input  1  serial line, idle high, asynchronous to clk
delitel  input  32  clk cycles per bit
parity_bit_mode  input  3  0 none, 1 even, 2 odd, 3 mark (1), 4 space (0), 5-7 treated as none
stop_bit_num  input  1  0 = one stop bit, 1 = two stop bits
rx_data  output  DATA_BITS  received payload
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
err_rx  output  1  one-cycle pulse: parity mismatch
err_stop  output  1  one-cycle pulse: stop bit sampled low
err_rx_dropped  output  1  one-cycle pulse: completed byte lost to overrun

Behaviour:
- Reset values: rx_data 0, rx_valid 0, all err pulses 0. State IDLE, counters 0, synchroniser flops 1.
- rx passes through SYNC_STAGES flops. All decisions use the synchronised value rxs.
- Effective divisor div = max(delitel, 2). It is latched at start detection. delitel, parity_bit_mode and stop_bit_num changes mid-frame are ignored until the next frame.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
- IDLE: rxs==0 -> START, baud counter cleared.
- START: after div>>1 cycles, sample rxs.
  - 0 -> DATA, counter reload.
  - 1 -> false start, back to IDLE with no output.
- DATA: sample every div cycles (mid-bit). Shift LSB first. After DATA_BITS samples -> PARITY if the mode is 1-4, else STOP1.
- PARITY: sample once. Expected bit:
  - even: XOR of data
  - odd: inverted XOR
  - mark: 1
  - space: 0
  - A mismatch sets an internal flag.
- STOP1: sample once.
  - 0 -> framing error.
  - 1 and stop_bit_num==1 -> STOP2, else frame complete.
- STOP2: sample once. 0 -> framing error, else frame complete.
- Frame complete, registered, visible the cycle after the final stop-sample edge:
  - If rx_valid==0, or rx_valid && rx_ready in that same cycle: load rx_data, rx_valid=1.
  - Else keep the old rx_data and pulse err_rx_dropped for 1 cycle.
  - Parity flag set -> err_rx pulses in the same cycle. The byte is still delivered (or dropped) as above.
  - Next state IDLE. A new start bit may be detected from the following cycle.
- Framing error: err_stop pulses 1 cycle. The byte is discarded (no rx_valid, no err_rx, no err_rx_dropped). Next state WAIT_IDLE.
- WAIT_IDLE: stay until rxs==1 (break condition), then IDLE.
- rx_valid clears on the cycle after rx_valid && rx_ready, unless a new byte loads in that same cycle.
- err pulses never stretch. Back-to-back events produce separate pulses.
- Reset asserted mid-frame: immediate return to reset values. Partial data is lost and no error pulses are produced.
- Baud counter is 32-bit. Sampling at mid-bit uses div>>1 for odd div, truncating.

Test Plan:
- delitel=16, parity 0, stop 0, send 0xA5 8N1 with rx_ready=1 -> rx_data=0xA5, rx_valid high 1 cycle, no errors. rx_valid rises within 2+SYNC_STAGES cycles after mid of stop bit.
- delitel=16, parity 1 (even), send 0x3C with parity bit 1 (wrong) -> rx_data=0x3C, rx_valid=1, err_rx pulses once. Repeat with parity bit 0 -> no err_rx.
- delitel=10, stop_bit_num=1, send 0x55 with second stop bit low -> err_stop pulses once, rx_valid stays 0. Hold rx low 40 cycles then high -> state returns IDLE, next frame 0x12 received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and err_rx_dropped pulses once. Then rx_ready=1 coincident with completion of a third byte 0x33 -> rx_data=0x33, no drop pulse.
- delitel=16, 4-cycle low glitch on idle rx -> no rx_valid, no error pulses. A following valid 0x80 frame is received correctly.
- Assert rst_n=0 during DATA bit 4 of a frame, release, send 0xF0 -> only 0xF0 delivered. All outputs 0 during reset.
